ray_column_flattener: RTL and testbench
=======================================

Name: ray_column_flattener

Overview:
Upstream write-side feeder for the double-buffered frame buffer. It accepts one ray result per screen column from the raycaster (DDA). Each result carries the column index, wall height, wall colour and side flag. The block expands each result into SCREEN_HEIGHT RGB565 pixel writes: ceiling, then wall, then floor. It produces flat frame-buffer addresses (row*SCREEN_WIDTH + col) and a last-pixel strobe. It then stalls until the frame buffer reports a completed buffer swap.

Parameters:
SCREEN_WIDTH, 320, columns per frame; ray_col_in range 0..SCREEN_WIDTH-1.
SCREEN_HEIGHT, 180, rows per column; also the wall-height clamp.
CEILING_COLOR, 16'h2104, RGB565 value for rows above the wall.
FLOOR_COLOR, 16'h4208, RGB565 value for rows below the wall.

Ports:
pixel_clk_in  in  1  system clock; all logic on its rising edge.
rst_in  in  1  reset; synchronous, active-high.
ray_valid_in  in  1  ray result present.
ray_ready_out  out  1  block can accept a ray result; transfer occurs when valid && ready.
ray_col_in  in  9  screen column of the ray.
wall_height_in  in  8  projected wall height in rows.
wall_color_in  in  16  RGB565 wall colour.
wall_side_in  in  1  1 = side face; wall colour is darkened.
fb_ready_to_switch_in  in  2  frame buffer swap status; 2'b11 means swap is occurring this cycle.
ray_address_out  out  16  frame-buffer write address.
ray_pixel_out  out  16  RGB565 pixel to write.
ray_valid_out  out  1  address/pixel pair is a fresh write this cycle.
ray_last_pixel_out  out  1  one-cycle strobe on the final pixel of the frame.

Behaviour:
- Reset values:
  - state = IDLE.
  - ray_address_out = 0, ray_pixel_out = 0, ray_valid_out = 0, ray_last_pixel_out = 0.
  - ray_ready_out = 0 while rst_in is high.
  - Reset mid-column or mid-WAIT_SWAP abandons all work.
- ray_ready_out = (state == IDLE) && !rst_in. It is high on the first cycle after reset deasserts.
- States:
  - IDLE → DRAW on a transfer with ray_col_in < SCREEN_WIDTH.
  - A transfer with ray_col_in >= SCREEN_WIDTH is consumed and dropped. Stay in IDLE; no writes.
  - DRAW → IDLE after row SCREEN_HEIGHT-1 of a column other than SCREEN_WIDTH-1.
  - DRAW → WAIT_SWAP after row SCREEN_HEIGHT-1 of column SCREEN_WIDTH-1.
  - WAIT_SWAP → IDLE on the cycle fb_ready_to_switch_in == 2'b11 is sampled.
- On accept, latch the following:
  - col.
  - h = min(wall_height_in, SCREEN_HEIGHT).
  - top = (SCREEN_HEIGHT - h) >> 1.
  - bottom = top + h.
  - wall pixel = wall_side_in ? {R>>1, G>>1, B>>1} on 5/6/5 fields : wall_color_in.
- DRAW emits one pixel per cycle, row r = 0..SCREEN_HEIGHT-1, on registered outputs.
  - Row 0 appears on the cycle after the accept edge.
  - Address starts at col and increments by SCREEN_WIDTH per row; no multiplier. Maximum address is SCREEN_WIDTH*SCREEN_HEIGHT-1 = 57599, which fits in 16 bits.
  - Pixel = CEILING_COLOR when r < top; wall pixel when top <= r < bottom; FLOOR_COLOR when r >= bottom.
  - h = 0 gives no wall rows.
- ray_valid_out = 1 on every DRAW output cycle, otherwise 0.
- Outside DRAW, ray_address_out and ray_pixel_out hold their last values. The frame buffer writes every enabled cycle, so a held pair is an idempotent rewrite of the same pixel.
- ray_last_pixel_out = 1 for exactly the cycle carrying address (SCREEN_HEIGHT-1)*SCREEN_WIDTH + SCREEN_WIDTH-1, together with ray_valid_out = 1.
- Throughput: one column per SCREEN_HEIGHT+1 cycles (SCREEN_HEIGHT DRAW cycles plus 1 IDLE accept cycle). ray_ready_out is never high in DRAW or WAIT_SWAP.
- Columns are not checked for order or duplication. The last-pixel strobe is keyed only to column SCREEN_WIDTH-1.
- In WAIT_SWAP, fb_ready_to_switch_in values 2'b00, 2'b01 and 2'b10 hold the state.
- fb_ready_to_switch_in is ignored in IDLE and DRAW.

Test Plan:
- Reset, then col=5, h=100, color=16'hF800, side=0, valid held 1 → ready drops next cycle.
  - 180 valid writes follow.
  - Rows 0–39 = 16'h2104; rows 40–139 = 16'hF800 (row 40 addr 12805); rows 140–179 = 16'h4208.
  - Final address 57285; ready high on the following cycle.
- col=0, h=200, side=1, color=16'hFFFF → all 180 rows = 16'h7BEF (height clamped to 180, colour darkened). Addresses 0, 320, …, 57280.
- col=10, h=0 → 90 ceiling rows then 90 floor rows; no wall pixel.
- col=319, h=1 → wall at row 89 only.
  - ray_last_pixel_out pulses once, with addr 57599.
  - ready stays 0 through fb_ready_to_switch_in = 01, 01, 00.
  - ready returns 1 the cycle after 11 is sampled.
- col=400 presented → ready stays 1, ray_valid_out stays 0, no state change.
- rst_in asserted at row 60 of a column → next cycle all outputs 0 and state IDLE; a new ray is accepted normally afterwards.

Source files
------------

// File: rtl/ray_column_flattener_if.sv
// Ray-result handshake, swap status and pixel-write bus between the raycaster and the frame buffer.
// The slave modport is the flattener's view; master is the view of whatever drives and observes it.
interface ray_column_flattener_if;
    logic        ray_valid_in;
    logic        ray_ready_out;
    logic [8:0]  ray_col_in;
    logic [7:0]  wall_height_in;
    logic [15:0] wall_color_in;
    logic        wall_side_in;
    logic [1:0]  fb_ready_to_switch_in;
    logic [15:0] ray_address_out;
    logic [15:0] ray_pixel_out;
    logic        ray_valid_out;
    logic        ray_last_pixel_out;

    modport slave (
        input  ray_valid_in,
        output ray_ready_out,
        input  ray_col_in,
        input  wall_height_in,
        input  wall_color_in,
        input  wall_side_in,
        input  fb_ready_to_switch_in,
        output ray_address_out,
        output ray_pixel_out,
        output ray_valid_out,
        output ray_last_pixel_out
    );

    modport master (
        output ray_valid_in,
        input  ray_ready_out,
        output ray_col_in,
        output wall_height_in,
        output wall_color_in,
        output wall_side_in,
        output fb_ready_to_switch_in,
        input  ray_address_out,
        input  ray_pixel_out,
        input  ray_valid_out,
        input  ray_last_pixel_out
    );
endinterface

// File: rtl/ray_column_flattener.sv
// Expands one ray result into SCREEN_HEIGHT RGB565 writes (ceiling/wall/floor); row 0 one cycle after accept.
// Ready only in IDLE: one column per SCREEN_HEIGHT+1 cycles, and no rays after the last column until a swap.
module ray_column_flattener #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEILING_COLOR = 16'h2104,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_in,
    ray_column_flattener_if.slave        bus
);
    localparam logic [8:0]  LAST_COL   = 9'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  COL_LIMIT  = 10'(SCREEN_WIDTH);
    localparam logic [7:0]  HEIGHT     = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  LAST_ROW   = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] ROW_STRIDE = 16'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAW      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  top_q, top_d;
    logic [7:0]  bottom_q, bottom_d;
    logic [15:0] wall_q, wall_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] pix_q, pix_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    logic [7:0]  h_clamp;
    logic [7:0]  top_new;
    logic [7:0]  bottom_new;
    logic [15:0] wall_new;
    logic        col_in_range;

    function automatic logic [15:0] shade(input logic [7:0] row, input logic [7:0] top,
                                          input logic [7:0] bottom, input logic [15:0] wall);
        if (row < top) begin
            return CEILING_COLOR;
        end else if (row < bottom) begin
            return wall;
        end else begin
            return FLOOR_COLOR;
        end
    endfunction

    function automatic logic is_last(input logic [8:0] col, input logic [7:0] row);
        return (col == LAST_COL) && (row == LAST_ROW);
    endfunction

    // Side faces halve each 5/6/5 field independently so no channel bleeds into its neighbour.
    always_comb begin
        h_clamp      = (bus.wall_height_in > HEIGHT) ? HEIGHT : bus.wall_height_in;
        top_new      = (HEIGHT - h_clamp) >> 1;
        bottom_new   = top_new + h_clamp;
        wall_new     = bus.wall_side_in
                     ? {1'b0, bus.wall_color_in[15:12], 1'b0, bus.wall_color_in[10:6],
                        1'b0, bus.wall_color_in[4:1]}
                     : bus.wall_color_in;
        col_in_range = ({1'b0, bus.ray_col_in} < COL_LIMIT);
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        wall_d   = wall_q;
        addr_d   = addr_q;
        pix_d    = pix_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Out-of-range columns are still handshaken so the raycaster never stalls on them.
                if (bus.ray_valid_in && col_in_range) begin
                    col_d    = bus.ray_col_in;
                    top_d    = top_new;
                    bottom_d = bottom_new;
                    wall_d   = wall_new;
                    row_d    = 8'd0;
                    addr_d   = {7'd0, bus.ray_col_in};
                    pix_d    = shade(8'd0, top_new, bottom_new, wall_new);
                    valid_d  = 1'b1;
                    last_d   = is_last(bus.ray_col_in, 8'd0);
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (row_q == LAST_ROW) begin
                    state_d = (col_q == LAST_COL) ? WAIT_SWAP : IDLE;
                end else begin
                    row_d   = row_q + 8'd1;
                    addr_d  = addr_q + ROW_STRIDE;
                    pix_d   = shade(row_d, top_q, bottom_q, wall_q);
                    valid_d = 1'b1;
                    last_d  = is_last(col_q, row_d);
                end
            end
            WAIT_SWAP: begin
                if (bus.fb_ready_to_switch_in == 2'b11) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            top_q    <= '0;
            bottom_q <= '0;
            wall_q   <= '0;
            addr_q   <= '0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            wall_q   <= wall_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign bus.ray_ready_out      = (state_q == IDLE) && !rst_in;
    assign bus.ray_address_out    = addr_q;
    assign bus.ray_pixel_out      = pix_q;
    assign bus.ray_valid_out      = valid_q;
    assign bus.ray_last_pixel_out = last_q;
endmodule

// File: tb/tb_ray_column_flattener.sv
// Directed bench for ray_column_flattener: full-column pixel/address checks, swap wait, drop and reset cases.
module tb_ray_column_flattener;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ray_column_flattener_if bus ();

    ray_column_flattener dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one ray in IDLE and checks every row of the resulting column against hand-derived bounds.
    task automatic run_col(input logic [8:0] col, input logic [7:0] h, input logic [15:0] color,
                           input logic side, input int top, input int bot,
                           input logic [15:0] wall, input string tag);
        logic [15:0] exp_pix;
        bus.ray_col_in     = col;
        bus.wall_height_in = h;
        bus.wall_color_in  = color;
        bus.wall_side_in   = side;
        bus.ray_valid_in   = 1'b1;
        chk({tag, "_ready_offer"}, 32'(bus.ray_ready_out), 32'd1);
        tick();
        for (int r = 0; r < 180; r++) begin
            exp_pix = (r < top) ? 16'h2104 : ((r < bot) ? wall : 16'h4208);
            chk($sformatf("%s_pix_r%0d", tag, r), 32'(bus.ray_pixel_out), 32'(exp_pix));
            chk($sformatf("%s_addr_r%0d", tag, r), 32'(bus.ray_address_out), 32'(col) + 32'(r * 320));
            chk($sformatf("%s_vld_r%0d", tag, r), 32'(bus.ray_valid_out), 32'd1);
            chk($sformatf("%s_last_r%0d", tag, r), 32'(bus.ray_last_pixel_out),
                (col == 9'd319 && r == 179) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rdy_r%0d", tag, r), 32'(bus.ray_ready_out), 32'd0);
            if (r == 178) bus.ray_valid_in = 1'b0;
            tick();
        end
        chk({tag, "_vld_after"}, 32'(bus.ray_valid_out), 32'd0);
        chk({tag, "_last_after"}, 32'(bus.ray_last_pixel_out), 32'd0);
        chk({tag, "_addr_held"}, 32'(bus.ray_address_out), 32'(col) + 32'd57280);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.ray_valid_in          = 1'b0;
        bus.ray_col_in            = '0;
        bus.wall_height_in        = '0;
        bus.wall_color_in         = '0;
        bus.wall_side_in          = 1'b0;
        bus.fb_ready_to_switch_in = 2'b00;

        tick();
        tick();
        chk("rst_ready", 32'(bus.ray_ready_out), 32'd0);
        chk("rst_vld", 32'(bus.ray_valid_out), 32'd0);
        chk("rst_addr", 32'(bus.ray_address_out), 32'd0);
        chk("rst_pix", 32'(bus.ray_pixel_out), 32'd0);
        chk("rst_last", 32'(bus.ray_last_pixel_out), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.ray_ready_out), 32'd1);

        // h=100 -> top 40, bottom 140; row 40 address 12805, last address 57285.
        run_col(9'd5, 8'd100, 16'hF800, 1'b0, 40, 140, 16'hF800, "c5");
        chk("c5_ready_back", 32'(bus.ray_ready_out), 32'd1);

        // h=200 clamps to 180 and the side face darkens FFFF to 7BEF.
        run_col(9'd0, 8'd200, 16'hFFFF, 1'b1, 0, 180, 16'h7BEF, "c0");
        chk("c0_ready_back", 32'(bus.ray_ready_out), 32'd1);

        // fb status is ignored outside WAIT_SWAP.
        bus.fb_ready_to_switch_in = 2'b11;
        run_col(9'd10, 8'd0, 16'h1234, 1'b0, 90, 90, 16'h1234, "c10");
        chk("c10_ready_back", 32'(bus.ray_ready_out), 32'd1);
        bus.fb_ready_to_switch_in = 2'b00;

        run_col(9'd319, 8'd1, 16'h07E0, 1'b0, 89, 90, 16'h07E0, "c319");
        chk("ws_ready0", 32'(bus.ray_ready_out), 32'd0);
        chk("ws_pix_held", 32'(bus.ray_pixel_out), 32'h4208);
        bus.ray_valid_in = 1'b1;
        bus.ray_col_in   = 9'd3;
        bus.fb_ready_to_switch_in = 2'b01;
        tick();
        chk("ws_ready_01a", 32'(bus.ray_ready_out), 32'd0);
        chk("ws_vld_01a", 32'(bus.ray_valid_out), 32'd0);
        bus.fb_ready_to_switch_in = 2'b01;
        tick();
        chk("ws_ready_01b", 32'(bus.ray_ready_out), 32'd0);
        bus.fb_ready_to_switch_in = 2'b00;
        tick();
        chk("ws_ready_00", 32'(bus.ray_ready_out), 32'd0);
        bus.ray_valid_in = 1'b0;
        bus.fb_ready_to_switch_in = 2'b10;
        tick();
        chk("ws_ready_10", 32'(bus.ray_ready_out), 32'd0);
        bus.fb_ready_to_switch_in = 2'b11;
        tick();
        chk("ws_ready_11", 32'(bus.ray_ready_out), 32'd1);
        chk("ws_vld_11", 32'(bus.ray_valid_out), 32'd0);
        bus.fb_ready_to_switch_in = 2'b00;

        // Column 400 is consumed and dropped.
        bus.ray_col_in     = 9'd400;
        bus.wall_height_in = 8'd50;
        bus.ray_valid_in   = 1'b1;
        chk("c400_ready_offer", 32'(bus.ray_ready_out), 32'd1);
        tick();
        bus.ray_valid_in = 1'b0;
        chk("c400_ready", 32'(bus.ray_ready_out), 32'd1);
        chk("c400_vld", 32'(bus.ray_valid_out), 32'd0);
        chk("c400_addr_held", 32'(bus.ray_address_out), 32'd57599);
        tick();
        chk("c400_ready2", 32'(bus.ray_ready_out), 32'd1);
        chk("c400_vld2", 32'(bus.ray_valid_out), 32'd0);

        // Reset at row 60 of column 7 (h=50 -> top 65).
        bus.ray_col_in     = 9'd7;
        bus.wall_height_in = 8'd50;
        bus.wall_color_in  = 16'h001F;
        bus.wall_side_in   = 1'b0;
        bus.ray_valid_in   = 1'b1;
        tick();
        bus.ray_valid_in = 1'b0;
        for (int r = 0; r < 60; r++) tick();
        chk("mid_addr_r60", 32'(bus.ray_address_out), 32'd19207);
        chk("mid_pix_r60", 32'(bus.ray_pixel_out), 32'h2104);
        chk("mid_vld_r60", 32'(bus.ray_valid_out), 32'd1);
        rst = 1'b1;
        chk("mid_ready_in_rst", 32'(bus.ray_ready_out), 32'd0);
        tick();
        chk("mid_rst_addr", 32'(bus.ray_address_out), 32'd0);
        chk("mid_rst_pix", 32'(bus.ray_pixel_out), 32'd0);
        chk("mid_rst_vld", 32'(bus.ray_valid_out), 32'd0);
        chk("mid_rst_last", 32'(bus.ray_last_pixel_out), 32'd0);
        chk("mid_rst_ready", 32'(bus.ray_ready_out), 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_post_ready", 32'(bus.ray_ready_out), 32'd1);
        chk("mid_post_vld", 32'(bus.ray_valid_out), 32'd0);

        run_col(9'd100, 8'd180, 16'h0841, 1'b0, 0, 180, 16'h0841, "c100");
        chk("c100_ready_back", 32'(bus.ray_ready_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
